// File: rtl/sm_als_master.sv
// sm_als_master: SPI read master for an 8-bit ambient light sensor.
// One frame is a CS-low window with 16 SCK cycles. SCK idles high. The sensor
// shifts data out on each SCK fall, and the master samples it on each SCK rise.
// Frame layout, MSB first: 3 leading zeros, then 8 data bits, then 5 ignored bits.
//
// Ports:
//   i_clk        - single clock, all state on its rising edge
//   i_rst_n      - synchronous active-low reset
//   i_start      - conversion request, only looked at while idle
//   i_sdo        - serial data from the sensor
//   o_busy       - high from the cycle after start is accepted until back in idle
//   o_done       - one-cycle pulse at frame completion
//   o_value      - last converted light value, held between frames
//   o_frame_err  - last frame had a nonzero leading-zero field, held between frames
//   o_cs         - sensor chip select, active-low, registered
//   o_sck        - SPI clock, idle high, registered
`timescale 1ns/1ps
module sm_als_master #(
    parameter int unsigned DIV   = 4,  // clk cycles per SCK half-period (1..255)
    parameter int unsigned QUIET = 8   // min clk cycles of CS high between frames (1..255)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_sdo,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_value,
    output logic       o_frame_err,
    output logic       o_cs,
    output logic       o_sck
);

    localparam logic [7:0] DivM1   = 8'(DIV - 1);
    localparam logic [7:0] QuietM1 = 8'(QUIET - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShiftLo,
        StShiftHi,
        StQuiet
    } state_e;

    state_e      r_state, w_state_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic [4:0]  r_bits, w_bits_d;
    logic [15:0] r_shift, w_shift_d;
    logic        w_done_d;
    logic [7:0]  w_value_d;
    logic        w_ferr_d;
    logic        w_cs_d, w_sck_d, w_busy_d;
    logic        w_phase_end;

    assign w_phase_end = (r_cnt == 8'd0);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_bits_d  = r_bits;
        w_shift_d = r_shift;
        w_done_d  = 1'b0;
        w_value_d = o_value;
        w_ferr_d  = o_frame_err;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StSetup;
                    w_cnt_d   = DivM1;
                    w_bits_d  = 5'd0;
                end
            end
            StSetup: begin
                if (w_phase_end) begin
                    w_state_d = StShiftLo;
                    w_cnt_d   = DivM1;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StShiftLo: begin
                if (w_phase_end) begin
                    // SCK rises on this edge, so this is the only point where sdo is sampled.
                    w_state_d = StShiftHi;
                    w_cnt_d   = DivM1;
                    w_shift_d = {r_shift[14:0], i_sdo};
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StShiftHi: begin
                if (w_phase_end) begin
                    if (r_bits == 5'd15) begin
                        w_state_d = StQuiet;
                        w_cnt_d   = QuietM1;
                        w_bits_d  = 5'd0;
                        w_done_d  = 1'b1;
                        w_value_d = r_shift[12:5];
                        w_ferr_d  = |r_shift[15:13];
                    end else begin
                        w_state_d = StShiftLo;
                        w_cnt_d   = DivM1;
                        w_bits_d  = r_bits + 5'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StQuiet: begin
                if (w_phase_end) begin
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Pin outputs are decoded from the next state so they are registered
        // and line up with the state they describe.
        w_cs_d   = !((w_state_d == StSetup) || (w_state_d == StShiftLo) ||
                     (w_state_d == StShiftHi));
        w_sck_d  = (w_state_d != StShiftLo);
        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 8'd0;
            r_bits      <= 5'd0;
            r_shift     <= 16'd0;
            o_done      <= 1'b0;
            o_value     <= 8'h00;
            o_frame_err <= 1'b0;
            o_cs        <= 1'b1;
            o_sck       <= 1'b1;
            o_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_bits      <= w_bits_d;
            r_shift     <= w_shift_d;
            o_done      <= w_done_d;
            o_value     <= w_value_d;
            o_frame_err <= w_ferr_d;
            o_cs        <= w_cs_d;
            o_sck       <= w_sck_d;
            o_busy      <= w_busy_d;
        end
    end

endmodule

// File: tb/tb_sm_als_master.sv
// tb_sm_als_master: self-checking bench for sm_als_master.
// The main DUT uses DIV=4 and QUIET=8. A behavioural SPI slave drives it, and
// expected {frame_err, value} pairs go into a scoreboard when each frame starts.
// A second DUT uses DIV=1 and QUIET=8, with sdo tied high and start held high
// to check back-to-back frames.
`timescale 1ns/1ps
module tb_sm_als_master;

    localparam int unsigned DIV    = 4;
    localparam int unsigned QUIET  = 8;
    localparam int unsigned DIV2   = 1;
    localparam int unsigned QUIET2 = 8;

    logic       clk = 1'b0;
    logic       rst_n, start, sdo;
    logic       busy, done, ferr, cs, sck;
    logic [7:0] value;
    logic       start2;
    logic       busy2, done2, ferr2, cs2, sck2;
    logic [7:0] value2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] word_q[$];
    logic [8:0]  exp_q[$];

    always #5 clk = ~clk;

    sm_als_master #(.DIV(DIV), .QUIET(QUIET)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_sdo       (sdo),
        .o_busy      (busy),
        .o_done      (done),
        .o_value     (value),
        .o_frame_err (ferr),
        .o_cs        (cs),
        .o_sck       (sck)
    );

    sm_als_master #(.DIV(DIV2), .QUIET(QUIET2)) u_dut_b2b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start2),
        .i_sdo       (1'b1),
        .o_busy      (busy2),
        .o_done      (done2),
        .o_value     (value2),
        .o_frame_err (ferr2),
        .o_cs        (cs2),
        .o_sck       (sck2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the slave word and, if a completed frame is expected, its result.
    task automatic pulse_start(input logic [15:0] word, input bit expect_done);
        word_q.push_back(word);
        if (expect_done) exp_q.push_back({|word[15:13], word[12:5]});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("cs_after_start", cs, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done) check_val("done_timeout", done, 1);
    endtask

    // busy stays high from the done cycle through the last QUIET cycle.
    task automatic busy_tail();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("busy_tail", k, QUIET);
    endtask

    // SPI slave: on SCK fall it presents the next bit, MSB first. At all other
    // times sdo carries junk, so a sample taken anywhere but an SCK rise is wrong.
    initial begin : slave
        logic [15:0] cur;
        int          idx;
        logic        pcs, psck;
        sdo  = 1'b0;
        cur  = 16'h0;
        idx  = 15;
        pcs  = 1'b1;
        psck = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (cs) begin
                idx = 15;
                sdo = 1'($urandom_range(0, 1));
            end else begin
                if (pcs) cur = (word_q.size() > 0) ? word_q.pop_front() : 16'($urandom);
                if (psck && !sck) begin
                    if (idx >= 0) sdo = cur[idx];
                    idx--;
                end else if (!psck && sck) begin
                    sdo = 1'($urandom_range(0, 1));
                end
            end
            pcs  = cs;
            psck = sck;
        end
    end

    // Frame monitor and scoreboard for the main DUT.
    initial begin : monitor
        int         low_cnt, rises;
        logic       pcs, psck, pdone;
        logic [8:0] e;
        low_cnt = 0;
        rises   = 0;
        pcs     = 1'b1;
        psck    = 1'b1;
        pdone   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                low_cnt = 0;
                rises   = 0;
                check_val("rst_cs", cs, 1);
                check_val("rst_sck", sck, 1);
                check_val("rst_busy", busy, 0);
                check_val("rst_done", done, 0);
            end else begin
                if (sck !== psck) check_val("sck_toggle_cs_low", {pcs, cs}, 0);
                if (!cs) begin
                    low_cnt++;
                    if (!psck && sck) rises++;
                end else if (!pcs) begin
                    check_val("cs_low_len", low_cnt, 33 * DIV);
                    check_val("sck_rises", rises, 16);
                    low_cnt = 0;
                    rises   = 0;
                end
                if (done) begin
                    check_val("done_width", pdone, 0);
                    check_val("done_cs_high", cs, 1);
                    if (exp_q.size() == 0) begin
                        check_val("done_unexpected", done, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("value", value, e[7:0]);
                        check_val("frame_err", ferr, e[8]);
                    end
                end
            end
            pcs   = cs;
            psck  = sck;
            pdone = done;
        end
    end

    initial begin : main
        int   lo, hi, nd, frames, lowcnt;
        logic pc;
        rst_n  = 1'b0;
        start  = 1'b1;   // start held during reset must be ignored
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_value", value, 8'h00);
        check_val("rst_frame_err", ferr, 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_val("no_frame_from_reset_start", cs, 1);
        check_val("idle_busy", busy, 0);

        // Reset at about cycle 60 of a frame aborts it without a done pulse.
        pulse_start(16'hFFFF, 1'b0);
        repeat (58) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("abort_cs", cs, 1);
        check_val("abort_sck", sck, 1);
        check_val("abort_busy", busy, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("abort_value_kept", value, 8'h00);
        check_val("abort_ferr_kept", ferr, 0);

        pulse_start(16'h0AA0, 1'b1);
        wait_done();
        busy_tail();
        pulse_start(16'hFFFF, 1'b1);
        wait_done();
        busy_tail();
        pulse_start(16'h0000, 1'b1);
        wait_done();
        busy_tail();

        // Extra starts during an active frame are neither accepted nor queued.
        pulse_start(16'h5A5A, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (89) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        busy_tail();
        lowcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (!cs) lowcnt++;
        end
        check_val("no_queued_frame", lowcnt, 0);
        check_val("scoreboard_empty", exp_q.size(), 0);

        // Back-to-back frames on the DIV=1 instance, start held high.
        lo     = 0;
        hi     = 0;
        nd     = 0;
        frames = 0;
        start2 = 1'b1;
        pc     = cs2;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (!cs2) begin
                if (pc && frames > 0) check_val("b2b_gap_len", hi, QUIET2 + 1);
                if (pc) lo = 0;
                lo++;
            end else begin
                if (!pc) begin
                    check_val("b2b_frame_len", lo, 33 * DIV2);
                    frames++;
                    hi = 0;
                end
                hi++;
            end
            if (done2) begin
                nd++;
                check_val("b2b_value", value2, 8'hFF);
                check_val("b2b_frame_err", ferr2, 1);
                if (nd == 3) start2 = 1'b0;
            end
            pc = cs2;
        end
        check_val("b2b_done_count", nd, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
